ttt_engine: RTL and testbench

TTT_ENGINE -- requirements
Module: ttt_engine

---
 rtl/ttt_pkg.sv | 28 ++
 rtl/ttt_line_check.sv | 44 ++++
 rtl/ttt_engine.sv | 144 ++++++++++++++
 tb/tb_ttt_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe engine: cell codes, result codes and FSM states.
// Optional undo support is enabled by defining TTT_UNDO_EN.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_X    = 2'b01,
    RES_O    = 2'b10,
    RES_DRAW = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic cell_t player_code(input logic p);
    return p ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win/full detection over an N x N board for one player.
// Unaffected by TTT_UNDO_EN.
module ttt_line_check
  import ttt_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2*N*N-1:0] board,
  input  logic             player,
  output logic             win,
  output logic             full
);

  cell_t          w_code;
  logic [N*N-1:0] w_match;
  logic [N*N-1:0] w_occ;
  logic [N-1:0]   w_row;
  logic [N-1:0]   w_col;
  logic [N-1:0]   w_diag;
  logic [N-1:0]   w_anti;

  assign w_code = player_code(player);

  for (genvar k = 0; k < N*N; k++) begin : g_cell
    assign w_match[k] = (board[2*k +: 2] == w_code);
    assign w_occ[k]   = (board[2*k +: 2] != CELL_EMPTY);
  end

  // Columns are strided in the flat board, so gather them per line.
  for (genvar i = 0; i < N; i++) begin : g_line
    logic [N-1:0] w_colv;
    for (genvar j = 0; j < N; j++) begin : g_col
      assign w_colv[j] = w_match[j*N + i];
    end
    assign w_row[i]  = &w_match[i*N +: N];
    assign w_col[i]  = &w_colv;
    assign w_diag[i] = w_match[i*N + i];
    assign w_anti[i] = w_match[i*N + (N-1-i)];
  end

  assign win  = (|w_row) | (|w_col) | (&w_diag) | (&w_anti);
  assign full = &w_occ;

endmodule

// File: rtl/ttt_engine.sv
// Tic-tac-toe referee: accepts moves, rejects illegal ones, detects win/draw.
// Define TTT_UNDO_EN to add the one-level undo input.
module ttt_engine
  import ttt_pkg::*;
#(
  parameter int N  = 3,
  parameter int AW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
`ifdef TTT_UNDO_EN
  input  logic             undo,
`endif
  input  logic             move_valid,
  output logic             move_ready,
  input  logic [AW-1:0]    move_row,
  input  logic [AW-1:0]    move_col,
  input  logic             move_player,
  output logic             illegal,
  output logic             turn,
  output logic [1:0]       result,
  output logic             result_valid,
  output logic [2*N*N-1:0] board
);

  localparam int IW = $clog2(N*N);

  state_t           r_state;
  logic [2*N*N-1:0] r_board;
  logic             r_turn;
  result_t          r_result;
  logic             r_rv;
  logic             r_illegal;
  logic             r_ready;
`ifdef TTT_UNDO_EN
  logic             r_undo_vld;
  logic [IW-1:0]    r_undo_idx;
`endif

  logic          w_in_range;
  logic [IW-1:0] w_idx;
  logic [1:0]    w_cell;
  logic          w_legal;
  logic          w_win;
  logic          w_full;

  // w_idx may alias for out-of-range indices; w_in_range masks that case.
  assign w_in_range = (int'(move_row) < N) && (int'(move_col) < N);
  assign w_idx      = IW'(move_row) * IW'(N) + IW'(move_col);
  assign w_cell     = r_board[2*w_idx +: 2];
  assign w_legal    = w_in_range && (w_cell == CELL_EMPTY) && (move_player == r_turn);

  ttt_line_check #(.N(N)) u_line (
    .board  (r_board),
    .player (r_turn),
    .win    (w_win),
    .full   (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_board   <= '0;
      r_turn    <= 1'b0;
      r_result  <= RES_NONE;
      r_rv      <= 1'b0;
      r_illegal <= 1'b0;
      r_ready   <= 1'b0;
`ifdef TTT_UNDO_EN
      r_undo_vld <= 1'b0;
      r_undo_idx <= '0;
`endif
    end else begin
      r_illegal <= 1'b0;
      if (new_game) begin
        r_state  <= IDLE;
        r_board  <= '0;
        r_turn   <= 1'b0;
        r_result <= RES_NONE;
        r_rv     <= 1'b0;
        r_ready  <= 1'b1;
`ifdef TTT_UNDO_EN
        r_undo_vld <= 1'b0;
      end else if (undo) begin
        if (r_state == IDLE && r_undo_vld) begin
          r_board[2*r_undo_idx +: 2] <= CELL_EMPTY;
          r_turn     <= ~r_turn;
          r_undo_vld <= 1'b0;
        end else begin
          r_illegal <= 1'b1;
        end
`endif
      end else begin
        case (r_state)
          IDLE: begin
            r_ready <= 1'b1;
            if (move_valid && r_ready) begin
              if (w_legal) begin
                r_board[2*w_idx +: 2] <= player_code(r_turn);
                r_state <= CHECK;
                r_ready <= 1'b0;
`ifdef TTT_UNDO_EN
                r_undo_vld <= 1'b1;
                r_undo_idx <= w_idx;
`endif
              end else begin
                r_illegal <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (w_win) begin
              r_result <= r_turn ? RES_O : RES_X;
              r_rv     <= 1'b1;
              r_state  <= DONE;
            end else if (w_full) begin
              r_result <= RES_DRAW;
              r_rv     <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_turn  <= ~r_turn;
              r_state <= IDLE;
              r_ready <= 1'b1;
            end
          end
          DONE: r_ready <= 1'b0;
          default: begin
            r_state <= IDLE;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign move_ready   = r_ready;
  assign illegal      = r_illegal;
  assign turn         = r_turn;
  assign result       = r_result;
  assign result_valid = r_rv;
  assign board        = r_board;

endmodule

// File: tb/tb_ttt_engine.sv
// Directed bench for ttt_engine at N=3, 4 and 5; undo test runs when TTT_UNDO_EN is defined.
module tb_ttt_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ng  = 1'b0;
  logic [2:0] mv  = '0;
  logic [2:0] row = '0;
  logic [2:0] col = '0;
  logic       ply = 1'b0;
`ifdef TTT_UNDO_EN
  logic       undo = 1'b0;
`endif

  logic        rdy3, ill3, trn3, rv3;
  logic [1:0]  res3;
  logic [17:0] b3;
  logic        rdy4, ill4, trn4, rv4;
  logic [1:0]  res4;
  logic [31:0] b4;
  logic        rdy5, ill5, trn5, rv5;
  logic [1:0]  res5;
  logic [49:0] b5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ttt_engine #(.N(3)) u3 (
    .clk(clk), .rst(rst), .new_game(ng),
`ifdef TTT_UNDO_EN
    .undo(undo),
`endif
    .move_valid(mv[0]), .move_ready(rdy3), .move_row(row[1:0]), .move_col(col[1:0]),
    .move_player(ply), .illegal(ill3), .turn(trn3), .result(res3),
    .result_valid(rv3), .board(b3));

  ttt_engine #(.N(4)) u4 (
    .clk(clk), .rst(rst), .new_game(ng),
`ifdef TTT_UNDO_EN
    .undo(1'b0),
`endif
    .move_valid(mv[1]), .move_ready(rdy4), .move_row(row[1:0]), .move_col(col[1:0]),
    .move_player(ply), .illegal(ill4), .turn(trn4), .result(res4),
    .result_valid(rv4), .board(b4));

  ttt_engine #(.N(5)) u5 (
    .clk(clk), .rst(rst), .new_game(ng),
`ifdef TTT_UNDO_EN
    .undo(1'b0),
`endif
    .move_valid(mv[2]), .move_ready(rdy5), .move_row(row), .move_col(col),
    .move_player(ply), .illegal(ill5), .turn(trn5), .result(res5),
    .result_valid(rv5), .board(b5));

  // Presents one move for a single cycle; returns at the negedge where the result is visible.
  task automatic move(input int inst, input int r, input int c, input logic p, output logic ill);
    @(negedge clk);
    row = 3'(r); col = 3'(c); ply = p;
    mv[inst] = 1'b1;
    @(negedge clk);
    mv = '0;
    case (inst)
      0: ill = ill3;
      1: ill = ill4;
      default: ill = ill5;
    endcase
    @(negedge clk);
  endtask

  task automatic start_game();
    @(negedge clk);
    ng = 1'b1;
    @(negedge clk);
    ng = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (b3 !== 18'h0) begin errors++; $display("FAIL reset_board got=%h exp=0", b3); end
    checks++; if ({trn3, res3, rv3, ill3} !== 5'b0) begin errors++;
      $display("FAIL reset_flags got=%b exp=00000", {trn3, res3, rv3, ill3}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rdy3); end
  endtask

  task automatic test_win();
    logic ill;
    logic any_ill = 1'b0;
    start_game();
    move(0, 0, 0, 1'b0, ill); any_ill |= ill;
    move(0, 1, 0, 1'b1, ill); any_ill |= ill;
    move(0, 0, 1, 1'b0, ill); any_ill |= ill;
    move(0, 1, 1, 1'b1, ill); any_ill |= ill;
    checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL win_early_rv got=%b exp=0", rv3); end
    move(0, 0, 2, 1'b0, ill); any_ill |= ill;
    checks++; if (any_ill !== 1'b0) begin errors++; $display("FAIL win_no_illegal got=%b exp=0", any_ill); end
    checks++; if (res3 !== 2'b01 || rv3 !== 1'b1) begin errors++;
      $display("FAIL win_result got=%b/%b exp=01/1", res3, rv3); end
    checks++; if (b3 !== 18'h00295) begin errors++; $display("FAIL win_board got=%h exp=00295", b3); end
    move(0, 2, 2, 1'b1, ill);
    checks++; if (b3 !== 18'h00295 || ill !== 1'b0 || rdy3 !== 1'b0 || res3 !== 2'b01) begin errors++;
      $display("FAIL done_ignore got=%h ill=%b rdy=%b res=%b exp=00295 0 0 01", b3, ill, rdy3, res3); end
  endtask

  task automatic test_illegal();
    logic ill;
    start_game();
    move(0, 0, 0, 1'b0, ill);
    move(0, 0, 0, 1'b1, ill);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL occupied_illegal got=%b exp=1", ill); end
    checks++; if (ill3 !== 1'b0) begin errors++; $display("FAIL illegal_pulse_width got=%b exp=0", ill3); end
    checks++; if (b3 !== 18'h1 || trn3 !== 1'b1 || rdy3 !== 1'b1) begin errors++;
      $display("FAIL occupied_state got=%h trn=%b rdy=%b exp=00001 1 1", b3, trn3, rdy3); end
    move(0, 2, 2, 1'b0, ill);
    checks++; if (ill !== 1'b1 || b3 !== 18'h1) begin errors++;
      $display("FAIL wrong_player got=%b/%h exp=1/00001", ill, b3); end
    move(0, 3, 0, 1'b1, ill);
    checks++; if (ill !== 1'b1 || b3 !== 18'h1) begin errors++;
      $display("FAIL row_range got=%b/%h exp=1/00001", ill, b3); end
  endtask

  task automatic test_draw();
    logic ill;
    start_game();
    move(0, 0, 0, 1'b0, ill);
    move(0, 0, 1, 1'b1, ill);
    move(0, 0, 2, 1'b0, ill);
    move(0, 1, 1, 1'b1, ill);
    move(0, 1, 0, 1'b0, ill);
    move(0, 1, 2, 1'b1, ill);
    move(0, 2, 1, 1'b0, ill);
    move(0, 2, 0, 1'b1, ill);
    checks++; if (rv3 !== 1'b0 || trn3 !== 1'b0) begin errors++;
      $display("FAIL draw_eighth got rv=%b trn=%b exp=0 0", rv3, trn3); end
    move(0, 2, 2, 1'b0, ill);
    checks++; if (res3 !== 2'b11 || rv3 !== 1'b1) begin errors++;
      $display("FAIL draw_result got=%b/%b exp=11/1", res3, rv3); end
    checks++; if (b3 !== 18'h16A59) begin errors++; $display("FAIL draw_board got=%h exp=16a59", b3); end
  endtask

  task automatic test_n4_n5();
    logic ill;
    start_game();
    move(1, 0, 0, 1'b0, ill);
    move(1, 0, 3, 1'b1, ill);
    move(1, 0, 1, 1'b0, ill);
    move(1, 1, 2, 1'b1, ill);
    move(1, 0, 2, 1'b0, ill);
    move(1, 2, 1, 1'b1, ill);
    move(1, 1, 0, 1'b0, ill);
    checks++; if (rv4 !== 1'b0) begin errors++; $display("FAIL n4_early_rv got=%b exp=0", rv4); end
    move(1, 3, 0, 1'b1, ill);
    checks++; if (res4 !== 2'b10 || rv4 !== 1'b1) begin errors++;
      $display("FAIL n4_anti_diag got=%b/%b exp=10/1", res4, rv4); end
    move(2, 4, 4, 1'b0, ill);
    checks++; if (ill !== 1'b0 || b5[49:48] !== 2'b01) begin errors++;
      $display("FAIL n5_corner got ill=%b cell=%b exp=0 01", ill, b5[49:48]); end
    move(2, 4, 5, 1'b1, ill);
    checks++; if (ill !== 1'b1 || trn5 !== 1'b1) begin errors++;
      $display("FAIL n5_col_range got ill=%b trn=%b exp=1 1", ill, trn5); end
  endtask

  task automatic test_rst_check();
    logic ill;
    start_game();
    @(negedge clk);
    row = 3'd1; col = 3'd1; ply = 1'b0; mv[0] = 1'b1;
    @(negedge clk);
    mv = '0;
    rst = 1'b1;
    #1;
    checks++; if (b3 !== 18'h0 || trn3 !== 1'b0) begin errors++;
      $display("FAIL rst_mid_check got=%h trn=%b exp=0 0", b3, trn3); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdy3 !== 1'b1 || rv3 !== 1'b0 || b3 !== 18'h0) begin errors++;
      $display("FAIL rst_release got rdy=%b rv=%b b=%h exp=1 0 0", rdy3, rv3, b3); end
    move(0, 2, 0, 1'b0, ill);
    @(negedge clk);
    row = 3'd0; col = 3'd0; ply = 1'b1; mv[0] = 1'b1; ng = 1'b1;
    @(negedge clk);
    mv = '0; ng = 1'b0;
    checks++; if (b3 !== 18'h0 || ill3 !== 1'b0 || trn3 !== 1'b0 || rdy3 !== 1'b1) begin errors++;
      $display("FAIL newgame_vs_move got b=%h ill=%b trn=%b rdy=%b exp=0 0 0 1", b3, ill3, trn3, rdy3); end
  endtask

`ifdef TTT_UNDO_EN
  task automatic test_undo();
    logic ill;
    start_game();
    move(0, 1, 1, 1'b0, ill);
    @(negedge clk);
    undo = 1'b1;
    @(negedge clk);
    undo = 1'b0;
    checks++; if (b3 !== 18'h0 || trn3 !== 1'b0 || ill3 !== 1'b0) begin errors++;
      $display("FAIL undo_first got b=%h trn=%b ill=%b exp=0 0 0", b3, trn3, ill3); end
    @(negedge clk);
    undo = 1'b1;
    @(negedge clk);
    undo = 1'b0;
    checks++; if (ill3 !== 1'b1) begin errors++; $display("FAIL undo_second got=%b exp=1", ill3); end
  endtask
`endif

  initial begin
    test_reset();
    test_win();
    test_illegal();
    test_draw();
    test_n4_n5();
    test_rst_check();
`ifdef TTT_UNDO_EN
    test_undo();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
